// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port memory between instruction fetch and data access.
// Data wins ties; a lost-arbitration counter forces a fetch grant after MAX_WAIT losses.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned     CntW   = $clog2(MAX_WAIT + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_WAIT);

    typedef enum logic [1:0] {
        StIdle,
        StBusyIf,
        StBusyDm
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_valid_q, if_valid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              dm_valid_q, dm_valid_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic idle;
    logic if_wins;

    // Grants are suppressed while reset is held low.
    always_comb begin
        idle    = reset && (state_q == StIdle);
        if_wins = if_req && (!dm_req || (wait_cnt_q == MaxCnt));
        if_gnt  = idle && if_wins;
        dm_gnt  = idle && dm_req && !if_wins;
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_valid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_valid_d  = 1'b0;
        dm_rdata_d  = dm_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (if_gnt || !if_req) begin
                    wait_cnt_d = '0;
                end else if (dm_gnt && (wait_cnt_q != MaxCnt)) begin
                    wait_cnt_d = wait_cnt_q + CntW'(1);
                end

                if (dm_gnt) begin
                    state_d     = StBusyDm;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                end else if (if_gnt) begin
                    state_d     = StBusyIf;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                end
            end
            StBusyIf: begin
                if (mem_ready) begin
                    state_d    = StIdle;
                    mem_req_d  = 1'b0;
                    if_valid_d = 1'b1;
                    if_rdata_d = mem_rdata;
                end
            end
            StBusyDm: begin
                if (mem_ready) begin
                    state_d    = StIdle;
                    mem_req_d  = 1'b0;
                    dm_valid_d = 1'b1;
                    // Stores leave the last load data visible.
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d   = StIdle;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_valid_q  <= 1'b0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_valid_q  <= if_valid_d;
            if_rdata_q  <= if_rdata_d;
            dm_valid_q  <= dm_valid_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_valid  = if_valid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_valid  = dm_valid_q;
    assign dm_rdata  = dm_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one single-port unified memory between the instruction-fetch requester and the data-memory requester of the RISC-V core. Each transaction is latched, issued to memory with a ready handshake, and the response is returned to its owner. Data accesses have priority over fetches, and a bounded-starvation counter guarantees fetch progress. The block sits between the program counter / instruction path and the datapath load/store path on one side and the shared memory on the other.

## Interface
- ADDR_W, 32, address width (byte address, passed through unmodified)
- DATA_W, 32, data width
- MAX_WAIT, 3, consecutive lost arbitrations after which fetch wins (≥1)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-low; sampled on rising clk
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_valid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_W  fetched instruction, registered
- dm_req  in  1  data request; held with dm_we/addr/wdata stable until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  data request accepted this cycle (combinational)
- dm_valid  out  1  one-cycle pulse: load data ready / store complete
- dm_rdata  out  DATA_W  load data, registered
- mem_req  out  1  memory access active, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_W  memory address, registered
- mem_wdata  out  DATA_W  memory write data, registered
- mem_ready  in  1  memory completes the access this cycle
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1

## Operation
- States: IDLE, BUSY_IF, BUSY_DM.
- IDLE, arbitration:
  - dm_req only → grant DM.
  - if_req only → grant IF.
  - Both → grant DM unless wait_cnt == MAX_WAIT, then grant IF.
  - Neither → stay IDLE.
- Grant: the matching x_gnt=1 in that IDLE cycle. At the edge, mem_addr/mem_we/mem_wdata latch the requester's fields, mem_req←1, and the state moves to BUSY_x.
- IF grants force mem_we=0, mem_wdata=0.
- BUSY_x: mem_req held at 1 and all mem_* held stable for as many cycles as mem_ready=0.
- When mem_ready=1 in BUSY_x, at that edge:
  - mem_req←0, state←IDLE.
  - x_valid←1 for exactly one cycle.
  - Loads and fetches: x_rdata←mem_rdata.
  - Stores: dm_rdata is unchanged.
- x_rdata holds its value until the next completion of the same port.
- wait_cnt, width $clog2(MAX_WAIT+1):
  - Increments (saturating at MAX_WAIT) on each IDLE cycle with if_req=1 and dm_gnt=1.
  - Clears on if_gnt, or on any IDLE cycle with if_req=0.
- No grant is issued outside IDLE. x_gnt=0 in BUSY states regardless of requests.
- mem_ready is ignored in IDLE.
- No address/width arithmetic; addresses pass through.
- reset=0 at an edge:
  - State←IDLE, wait_cnt←0, mem_req/mem_we←0, mem_addr/mem_wdata←0.
  - if_valid/dm_valid←0, if_rdata/dm_rdata←0.
  - An in-flight access is abandoned: no valid pulse follows, and a late mem_ready is ignored.
  - While reset=0, if_gnt=dm_gnt=0.

## Timing
- Reset values: every output 0. if_gnt/dm_gnt are 0 while reset is low.
- Cycle N: request in IDLE, x_gnt=1. The requester may drop or change its request from N+1.
- N+1: mem_req=1. If mem_ready=1 in N+1, x_valid=1 in N+2.
- Minimum latency, request to valid: 2 cycles. Each memory wait state adds 1.
- The cycle in which x_valid=1 is an IDLE cycle and can grant a new request (back-to-back).
- Throughput: one transaction per 2 cycles with a zero-wait memory.
- A simultaneous mem_ready and reset=0 resolve as reset: no valid pulse.

## Test plan
- Single fetch, zero-wait: if_req=1, if_addr=0x0000_0010, mem_ready=1 on the first busy cycle with mem_rdata=0x0050_0093.
  - Required: if_gnt in cycle 0, mem_req=1 with mem_addr=0x10 in cycle 1, if_valid=1 with if_rdata=0x0050_0093 in cycle 2.
- Store with 2 wait states: dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0xDEAD_BEEF, mem_ready high on the 3rd busy cycle.
  - Required: mem_req/mem_we/mem_addr/mem_wdata stable for 3 cycles, one dm_valid pulse, dm_rdata unchanged (0).
- Simultaneous requests: if_req=dm_req=1 in the same IDLE cycle.
  - Required: dm_gnt=1, if_gnt=0. IF is granted in the IDLE cycle after DM completes.
- Starvation bound: MAX_WAIT=3, if_req held high while dm_req is re-asserted at every IDLE cycle.
  - Required: exactly 3 consecutive DM grants, then if_gnt=1 at the 4th arbitration, then wait_cnt=0.
- Reset mid-access: assert reset=0 in BUSY_DM with mem_ready=0, release reset, then drive mem_ready=1.
  - Required: all outputs 0 the cycle after the reset edge, no dm_valid pulse ever, state IDLE, a new request granted normally.
- Back-to-back fetches, zero-wait: if_req held with addresses 0x0, 0x4, 0x8.
  - Required: if_gnt in cycles 0, 2, 4 and if_valid in cycles 2, 4, 6 with the matching data.
